// File: rtl/mcoi_gbt_link_supervisor_if.sv
// Frame bus between the GBT RX core, the link supervisor and the motor application.
// Port summary: rx_valid_i/rx_data_i carry received 64-bit frames into the supervisor;
// payload_o/payload_valid_o carry qualified 52-bit payloads out to the application.
// master = frame source / payload sink side, slave = the supervisor.
interface mcoi_gbt_link_supervisor_if;
  logic        rx_valid_i;
  logic [63:0] rx_data_i;
  logic [51:0] payload_o;
  logic        payload_valid_o;

  modport master (
    output rx_valid_i,
    output rx_data_i,
    input  payload_o,
    input  payload_valid_o
  );

  modport slave (
    input  rx_valid_i,
    input  rx_data_i,
    output payload_o,
    output payload_valid_o
  );
endinterface

// File: rtl/mcoi_gbt_link_supervisor.sv
// GBT receive-side link supervisor: qualifies frames by sync nibble (and optionally by
// sequence number), runs the DOWN/ALIGN/LOCKED/LOST state machine with a watchdog,
// forwards payloads only while LOCKED and exports status / saturating error counters.
// Latency: frame in cycle N -> payload_valid_o and state change visible in cycle N+1.
// Backpressure: none; the application must accept one payload per cycle.
// Ports: ClkRs_ix (clk, sync active-high reset), sfp_los_i, link_ready_i, gbt_if (frames
// in, payload out), bitslip_reset_o, link_state_o, link_up_o, err_cnt_o, loss_cnt_o.
// Build option: define MCOI_GBT_SEQ_CHECK_EN to enable sequence-number checking.

package mcoi_gbt_link_supervisor_pkg;
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  typedef enum logic [1:0] {
    ST_DOWN   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } link_state_t;
endpackage

module mcoi_gbt_link_supervisor
  import mcoi_gbt_link_supervisor_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 16,
  parameter int unsigned LOSS_FRAMES = 4,
  parameter int unsigned WDOG_CYCLES = 4096,
  parameter logic [3:0]  SYNC_NIBBLE = 4'hA
) (
  input  ckrs_t                            ClkRs_ix,
  input  logic                             sfp_los_i,
  input  logic                             link_ready_i,
  mcoi_gbt_link_supervisor_if.slave        gbt_if,
  output logic                             bitslip_reset_o,
  output logic [1:0]                       link_state_o,
  output logic                             link_up_o,
  output logic [15:0]                      err_cnt_o,
  output logic [7:0]                       loss_cnt_o
);

  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam int BAD_W  = $clog2(LOSS_FRAMES + 1);
  localparam logic [GOOD_W-1:0] LOCK_LAST  = GOOD_W'(LOCK_FRAMES);
  localparam logic [BAD_W-1:0]  LOSS_LAST  = BAD_W'(LOSS_FRAMES);
  localparam logic [16:0]       WDOG_LIMIT = 17'(WDOG_CYCLES);

  logic w_clk;
  logic w_rst;
  assign w_clk = ClkRs_ix.clk;
  assign w_rst = ClkRs_ix.reset;

  link_state_t       r_state,       w_state_nxt;
  logic [GOOD_W-1:0] r_good_cnt,    w_good_cnt_nxt;
  logic [BAD_W-1:0]  r_bad_cnt,     w_bad_cnt_nxt;
  logic [15:0]       r_wdog,        w_wdog_nxt;
  logic [15:0]       r_err_cnt,     w_err_cnt_nxt;
  logic [7:0]        r_loss_cnt,    w_loss_cnt_nxt;
  logic [51:0]       r_payload,     w_payload_nxt;
  logic              r_payload_vld, w_payload_vld_nxt;
  logic              r_bitslip,     w_bitslip_nxt;
  logic              r_link_up,     w_link_up_nxt;

  logic              w_link_down;
  logic              w_sync_ok;
  logic              w_seq_ok;
  logic              w_frame_good;
  logic              w_frame_bad;
  logic [GOOD_W-1:0] w_good_inc;
  logic [BAD_W-1:0]  w_bad_inc;
  logic [16:0]       w_wdog_inc;
  logic [15:0]       w_err_inc;
  logic [7:0]        w_loss_inc;

  // Loss of signal or an unready RX core overrides everything, including the frame
  // strobed in the same cycle.
  assign w_link_down = sfp_los_i | ~link_ready_i;
  assign w_sync_ok   = (gbt_if.rx_data_i[63:60] == SYNC_NIBBLE);

`ifdef MCOI_GBT_SEQ_CHECK_EN
  logic [7:0] r_seq_ref, w_seq_ref_nxt;
  logic       r_seq_vld, w_seq_vld_nxt;

  // Until a reference exists the seq field cannot make a frame bad; the compare
  // wraps naturally at 8 bits so FF -> 00 is accepted.
  assign w_seq_ok = ~r_seq_vld | (gbt_if.rx_data_i[59:52] == (r_seq_ref + 8'd1));

  // The reference is only ever taken from good frames, so a bad frame never
  // resynchronises it; it is dropped whenever the link leaves ALIGN/LOCKED.
  always_comb begin
    w_seq_ref_nxt = r_seq_ref;
    w_seq_vld_nxt = r_seq_vld;
    if (w_link_down || r_state == ST_DOWN || r_state == ST_LOST) begin
      w_seq_vld_nxt = 1'b0;
    end else if (w_frame_good) begin
      w_seq_ref_nxt = gbt_if.rx_data_i[59:52];
      w_seq_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_seq_ref <= 8'd0;
      r_seq_vld <= 1'b0;
    end else begin
      r_seq_ref <= w_seq_ref_nxt;
      r_seq_vld <= w_seq_vld_nxt;
    end
  end
`else
  logic w_unused_seq;
  assign w_unused_seq = ^gbt_if.rx_data_i[59:52];
  assign w_seq_ok     = 1'b1;
`endif

  assign w_frame_good = gbt_if.rx_valid_i & w_sync_ok & w_seq_ok;
  assign w_frame_bad  = gbt_if.rx_valid_i & ~(w_sync_ok & w_seq_ok);

  assign w_good_inc = r_good_cnt + GOOD_W'(1);
  assign w_bad_inc  = r_bad_cnt + BAD_W'(1);
  assign w_wdog_inc = {1'b0, r_wdog} + 17'd1;
  assign w_err_inc  = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;
  assign w_loss_inc = (r_loss_cnt == 8'hFF) ? r_loss_cnt : r_loss_cnt + 8'd1;

  always_comb begin
    w_state_nxt       = r_state;
    w_good_cnt_nxt    = r_good_cnt;
    w_bad_cnt_nxt     = r_bad_cnt;
    w_wdog_nxt        = '0;
    w_err_cnt_nxt     = r_err_cnt;
    w_loss_cnt_nxt    = r_loss_cnt;
    w_payload_nxt     = r_payload;
    w_payload_vld_nxt = 1'b0;

    if (w_link_down) begin
      w_state_nxt    = ST_DOWN;
      w_good_cnt_nxt = '0;
      w_bad_cnt_nxt  = '0;
    end else begin
      case (r_state)
        ST_DOWN: begin
          w_state_nxt    = ST_ALIGN;
          w_good_cnt_nxt = '0;
          w_bad_cnt_nxt  = '0;
        end

        ST_ALIGN: begin
          if (w_frame_good) begin
            // The frame completing the lock count is consumed here, not forwarded.
            if (w_good_inc == LOCK_LAST) begin
              w_state_nxt    = ST_LOCKED;
              w_good_cnt_nxt = '0;
              w_bad_cnt_nxt  = '0;
            end else begin
              w_good_cnt_nxt = w_good_inc;
            end
          end else if (w_frame_bad) begin
            w_good_cnt_nxt = '0;
            w_err_cnt_nxt  = w_err_inc;
          end
        end

        ST_LOCKED: begin
          if (gbt_if.rx_valid_i) begin
            // Any strobe feeds the watchdog, so a frame on the expiry cycle wins.
            if (w_frame_good) begin
              w_bad_cnt_nxt     = '0;
              w_payload_nxt     = gbt_if.rx_data_i[51:0];
              w_payload_vld_nxt = 1'b1;
            end else begin
              w_err_cnt_nxt = w_err_inc;
              if (w_bad_inc == LOSS_LAST) begin
                w_state_nxt    = ST_LOST;
                w_bad_cnt_nxt  = '0;
                w_loss_cnt_nxt = w_loss_inc;
              end else begin
                w_bad_cnt_nxt = w_bad_inc;
              end
            end
          end else if (w_wdog_inc == WDOG_LIMIT) begin
            w_state_nxt    = ST_LOST;
            w_bad_cnt_nxt  = '0;
            w_loss_cnt_nxt = w_loss_inc;
          end else begin
            w_wdog_nxt = w_wdog_inc[15:0];
          end
        end

        ST_LOST: begin
          w_state_nxt    = ST_ALIGN;
          w_good_cnt_nxt = '0;
          w_bad_cnt_nxt  = '0;
        end

        default: begin
          w_state_nxt = ST_DOWN;
        end
      endcase
    end

    w_bitslip_nxt = (w_state_nxt != ST_DOWN);
    w_link_up_nxt = (w_state_nxt == ST_LOCKED);
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state       <= ST_DOWN;
      r_good_cnt    <= '0;
      r_bad_cnt     <= '0;
      r_wdog        <= '0;
      r_err_cnt     <= '0;
      r_loss_cnt    <= '0;
      r_payload     <= '0;
      r_payload_vld <= 1'b0;
      r_bitslip     <= 1'b0;
      r_link_up     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_good_cnt    <= w_good_cnt_nxt;
      r_bad_cnt     <= w_bad_cnt_nxt;
      r_wdog        <= w_wdog_nxt;
      r_err_cnt     <= w_err_cnt_nxt;
      r_loss_cnt    <= w_loss_cnt_nxt;
      r_payload     <= w_payload_nxt;
      r_payload_vld <= w_payload_vld_nxt;
      r_bitslip     <= w_bitslip_nxt;
      r_link_up     <= w_link_up_nxt;
    end
  end

  assign link_state_o           = r_state;
  assign bitslip_reset_o        = r_bitslip;
  assign link_up_o              = r_link_up;
  assign err_cnt_o              = r_err_cnt;
  assign loss_cnt_o             = r_loss_cnt;
  assign gbt_if.payload_o       = r_payload;
  assign gbt_if.payload_valid_o = r_payload_vld;

endmodule

// File: tb/tb_mcoi_gbt_link_supervisor.sv
// Testbench for mcoi_gbt_link_supervisor: directed scenarios plus a randomized phase,
// every cycle compared against a frame-level reference model of the link rules.
module tb_mcoi_gbt_link_supervisor;
  localparam int         LOCK_FRAMES = 16;
  localparam int         LOSS_FRAMES = 4;
  localparam int         WDOG_CYCLES = 4096;
  localparam logic [3:0] SYNC        = 4'hA;
`ifdef MCOI_GBT_SEQ_CHECK_EN
  localparam bit SEQ_CHK = 1'b1;
`else
  localparam bit SEQ_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] clk_rs;
  logic       sfp_los = 1'b0;
  logic       link_ready = 1'b0;
  logic       bitslip_reset;
  logic [1:0] link_state;
  logic       link_up;
  logic [15:0] err_cnt;
  logic [7:0]  loss_cnt;

  // Packed {clk, reset} matches the clock/reset bundle layout of the DUT port.
  assign clk_rs = {clk, rst};

  mcoi_gbt_link_supervisor_if gbt ();

  mcoi_gbt_link_supervisor #(
    .LOCK_FRAMES(LOCK_FRAMES),
    .LOSS_FRAMES(LOSS_FRAMES),
    .WDOG_CYCLES(WDOG_CYCLES),
    .SYNC_NIBBLE(SYNC)
  ) u_dut (
    .ClkRs_ix       (clk_rs),
    .sfp_los_i      (sfp_los),
    .link_ready_i   (link_ready),
    .gbt_if         (gbt.slave),
    .bitslip_reset_o(bitslip_reset),
    .link_state_o   (link_state),
    .link_up_o      (link_up),
    .err_cnt_o      (err_cnt),
    .loss_cnt_o     (loss_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: link state 0..3, run lengths, idle-cycle count, last good seq.
  int          m_state = 0;
  int          m_good  = 0;
  int          m_bad   = 0;
  int          m_idle  = 0;
  int          m_ref   = -1;
  int          m_err   = 0;
  int          m_loss  = 0;
  bit          m_pv    = 1'b0;
  logic [51:0] m_pl    = '0;

  function automatic bit m_is_good(input logic [63:0] d);
    if (d[63:60] != SYNC) return 1'b0;
    if (!SEQ_CHK || m_ref < 0) return 1'b1;
    return int'(d[59:52]) == ((m_ref + 1) % 256);
  endfunction

  task automatic m_step(input bit v, input logic [63:0] d, input bit los, input bit rdy, input bit r);
    bit g;
    m_pv = 1'b0;
    if (r) begin
      m_state = 0; m_good = 0; m_bad = 0; m_idle = 0; m_ref = -1;
      m_err = 0; m_loss = 0; m_pl = '0;
      return;
    end
    if (los || !rdy) begin
      m_state = 0; m_good = 0; m_bad = 0; m_idle = 0; m_ref = -1;
      return;
    end
    g = v && m_is_good(d);
    case (m_state)
      0: m_state = 1;
      3: begin m_state = 1; m_good = 0; m_bad = 0; m_idle = 0; m_ref = -1; end
      1: if (v) begin
        if (g) begin
          m_ref = int'(d[59:52]);
          m_good++;
          if (m_good == LOCK_FRAMES) begin
            m_state = 2; m_good = 0; m_bad = 0; m_idle = 0;
          end
        end else begin
          m_good = 0;
          m_err  = (m_err < 65535) ? m_err + 1 : m_err;
        end
      end
      default: if (v) begin
        m_idle = 0;
        if (g) begin
          m_ref = int'(d[59:52]); m_bad = 0; m_pv = 1'b1; m_pl = d[51:0];
        end else begin
          m_err = (m_err < 65535) ? m_err + 1 : m_err;
          m_bad++;
          if (m_bad == LOSS_FRAMES) begin
            m_state = 3; m_bad = 0;
            m_loss  = (m_loss < 255) ? m_loss + 1 : m_loss;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == WDOG_CYCLES) begin
          m_state = 3; m_idle = 0; m_bad = 0;
          m_loss  = (m_loss < 255) ? m_loss + 1 : m_loss;
        end
      end
    endcase
  endtask

  // One clock: drive at negedge, update the model, compare all outputs #1 after posedge.
  task automatic tick(input bit v, input logic [63:0] d, input bit los, input bit rdy, input bit r);
    @(negedge clk);
    gbt.rx_valid_i = v;
    gbt.rx_data_i  = d;
    sfp_los        = los;
    link_ready     = rdy;
    rst            = r;
    m_step(v, d, los, rdy, r);
    @(posedge clk);
    #1;
    check("state",    64'(link_state),         64'(m_state));
    check("bitslip",  64'(bitslip_reset),      64'(m_state != 0));
    check("link_up",  64'(link_up),            64'(m_state == 2));
    check("pay_vld",  64'(gbt.payload_valid_o), 64'(m_pv));
    check("payload",  64'(gbt.payload_o),      64'(m_pl));
    check("err_cnt",  64'(err_cnt),            64'(m_err));
    check("loss_cnt", 64'(loss_cnt),           64'(m_loss));
  endtask

  int tx_seq = 0;

  function automatic logic [63:0] mk(input logic [3:0] s, input logic [7:0] q);
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[63:60] = s;
    d[59:52] = q;
    return d;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic send_good();
    tick(1'b1, mk(SYNC, 8'(tx_seq)), 1'b0, 1'b1, 1'b0);
    tx_seq = (tx_seq + 1) % 256;
  endtask

  task automatic send_bad_sync();
    tick(1'b1, mk(4'h5, 8'(tx_seq)), 1'b0, 1'b1, 1'b0);
  endtask

  task automatic lock_up();
    for (int i = 0; i < LOCK_FRAMES; i++) begin
      send_good();
      idle($urandom_range(1));
    end
  endtask

  initial begin
    int err_snap;
    gbt.rx_valid_i = 1'b0;
    gbt.rx_data_i  = '0;

    // Reset values
    tick(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    tick(1'b1, mk(SYNC, 8'd0), 1'b0, 1'b1, 1'b1);
    check("rst_state", 64'(link_state), 64'd0);
    check("rst_bitslip", 64'(bitslip_reset), 64'd0);

    // Leave DOWN, lock on seq 0..15, forward seq 16
    idle(1);
    check("align_state", 64'(link_state), 64'd1);
    tx_seq = 0;
    for (int i = 0; i < LOCK_FRAMES; i++) send_good();
    check("lock_state", 64'(link_state), 64'd2);
    check("lock_no_fwd", 64'(gbt.payload_valid_o), 64'd0);
    send_good();
    check("first_fwd", 64'(gbt.payload_valid_o), 64'd1);

    // Four bad-sync frames -> LOST for one cycle -> ALIGN
    for (int i = 0; i < LOSS_FRAMES; i++) send_bad_sync();
    check("lost_state", 64'(link_state), 64'd3);
    idle(1);
    check("lost_to_align", 64'(link_state), 64'd1);
    check("lost_err", 64'(err_cnt), 64'd4);
    check("lost_loss", 64'(loss_cnt), 64'd1);

    // Relock ending at seq 20, then jump to 22 and 23
    tx_seq = 5;
    lock_up();
    tick(1'b1, mk(SYNC, 8'd22), 1'b0, 1'b1, 1'b0);
    tick(1'b1, mk(SYNC, 8'd23), 1'b0, 1'b1, 1'b0);
    check("jump_locked", 64'(link_state), 64'd2);
    tx_seq = 21;
    send_good();
    send_good();

    // Watchdog: frame on the expiry cycle keeps the lock, full silence loses it
    idle(WDOG_CYCLES - 1);
    send_good();
    check("wdog_saved", 64'(link_state), 64'd2);
    idle(WDOG_CYCLES - 1);
    check("wdog_pre", 64'(link_state), 64'd2);
    idle(1);
    check("wdog_lost", 64'(link_state), 64'd3);
    idle(1);

    // One-cycle LOS pulse with a frame in the same cycle
    lock_up();
    check("relock", 64'(link_state), 64'd2);
    tick(1'b1, mk(SYNC, 8'(tx_seq)), 1'b1, 1'b1, 1'b0);
    check("los_down", 64'(link_state), 64'd0);
    check("los_bitslip", 64'(bitslip_reset), 64'd0);
    idle(1);
    for (int i = 0; i < LOCK_FRAMES - 1; i++) send_good();
    check("los_not_yet", 64'(link_state), 64'd1);
    send_good();
    check("los_relock", 64'(link_state), 64'd2);

    // Seq wrap 254, 255, 0, 1 while LOCKED
    for (int i = 0; i < LOSS_FRAMES; i++) send_bad_sync();
    idle(1);
    tx_seq = 238;
    for (int i = 0; i < LOCK_FRAMES; i++) send_good();
    err_snap = int'(err_cnt);
    for (int i = 0; i < 4; i++) begin
      send_good();
      check("wrap_fwd", 64'(gbt.payload_valid_o), 64'd1);
    end
    check("wrap_err", 64'(err_cnt), 64'(err_snap));

    // Reset in the middle of a frame
    tick(1'b1, mk(SYNC, 8'(tx_seq)), 1'b0, 1'b1, 1'b1);
    check("midrst_err", 64'(err_cnt), 64'd0);
    check("midrst_loss", 64'(loss_cnt), 64'd0);

    // Randomized traffic with sync errors, seq jumps, LOS, not-ready and resets
    for (int c = 0; c < 3000; c++) begin
      bit          v, los, rdy, r;
      logic [3:0]  s;
      logic [7:0]  q;
      r   = ($urandom_range(999) == 0);
      los = ($urandom_range(199) == 0);
      rdy = ($urandom_range(199) != 0);
      v   = ($urandom_range(3) != 0);
      s   = ($urandom_range(29) == 0) ? 4'($urandom) : SYNC;
      q   = ($urandom_range(59) == 0) ? 8'($urandom) : 8'(tx_seq);
      if (v) tx_seq = (int'(q) + 1) % 256;
      tick(v, mk(s, q), los, rdy, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
